// File: rtl/lock_code_checker.sv
// lock_code_checker
//   Assembles a CODE_LEN-digit BCD entry from the digit-select counters,
//   compares it with the stored combination and drives the lock indications.
//
//   Ports
//     clk        in   system clock, rising edge
//     rst        in   asynchronous active-high reset
//     digit[3:0] in   BCD digit from the selector counter
//     enter      in   single-cycle pulse, commit digit
//     clear      in   single-cycle pulse, abandon partial entry
//     prog       in   (LOCK_REPROGRAM_EN only) program a new code while open
//     unlock     out  lock open
//     error      out  one-cycle pulse on mismatch / invalid digit
//     lockout    out  high during lockout
//     digit_idx  out  digits captured in the current entry
//     fail_cnt   out  consecutive mismatches
//
//   Optional feature: define LOCK_REPROGRAM_EN to add the prog input and a
//   runtime code register that can be rewritten while the lock is open.
module lock_code_checker #(
  parameter int          CODE_LEN       = 4,
  parameter logic [31:0] CODE           = 32'h0000_1234,
  parameter int          MAX_FAIL       = 3,
  parameter int          OPEN_CYCLES    = 8,
  parameter int          LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       clear,
`ifdef LOCK_REPROGRAM_EN
  input  logic       prog,
`endif
  output logic       unlock,
  output logic       error,
  output logic       lockout,
  output logic [2:0] digit_idx,
  output logic [3:0] fail_cnt
);

  localparam int EW   = CODE_LEN * 4;
  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [EW-1:0] CODE_USED = CODE[EW-1:0];
  localparam logic [2:0]    LAST_IDX  = 3'(CODE_LEN - 1);
  localparam logic [3:0]    FAIL_MAX  = 4'(MAX_FAIL);
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  state_t        r_state, w_state_n;
  logic [EW-1:0] r_entry, w_entry_n;
  logic [2:0]    r_idx,   w_idx_n;
  logic [3:0]    r_fail,  w_fail_n;
  logic [TW-1:0] r_timer, w_timer_n;
  logic          r_err,   w_err_n;
  logic [EW-1:0] w_code;
  logic          w_valid;
  logic          w_last;
  logic [3:0]    w_fail_inc;

`ifdef LOCK_REPROGRAM_EN
  logic [EW-1:0] r_code, w_code_n;
  assign w_code = r_code;
`else
  assign w_code = CODE_USED;
`endif

  assign w_valid    = (digit <= 4'd9);
  assign w_last     = (r_idx == LAST_IDX);
  assign w_fail_inc = (r_fail < FAIL_MAX) ? r_fail + 4'd1 : FAIL_MAX;

  always_comb begin
    w_state_n = r_state;
    w_entry_n = r_entry;
    w_idx_n   = r_idx;
    w_fail_n  = r_fail;
    w_timer_n = r_timer;
    w_err_n   = 1'b0;
`ifdef LOCK_REPROGRAM_EN
    w_code_n  = r_code;
`endif
    case (r_state)
      IDLE, ENTRY: begin
        if (clear) begin
          w_idx_n   = '0;
          w_state_n = IDLE;
        end else if (enter) begin
          if (w_valid) begin
            // first digit lands in the most significant nibble
            w_entry_n[(CODE_LEN-1-int'(r_idx))*4 +: 4] = digit;
            if (w_last) begin
              w_idx_n   = '0;
              w_state_n = CHECK;
            end else begin
              w_idx_n   = r_idx + 3'd1;
              w_state_n = ENTRY;
            end
          end else begin
            w_err_n = 1'b1;
          end
        end
      end
      CHECK: begin
        if (r_entry == w_code) begin
          w_state_n = OPEN;
          w_fail_n  = '0;
          w_timer_n = OPEN_LOAD;
        end else begin
          w_err_n  = 1'b1;
          w_fail_n = w_fail_inc;
          if (w_fail_inc == FAIL_MAX) begin
            w_state_n = LOCKOUT;
            w_timer_n = LOCK_LOAD;
          end else begin
            w_state_n = IDLE;
          end
        end
      end
      OPEN: begin
        if (r_timer == '0) begin
          w_state_n = IDLE;
          w_idx_n   = '0;
        end else begin
          w_timer_n = r_timer - 1'b1;
        end
`ifdef LOCK_REPROGRAM_EN
        // a programming entry completes or aborts back to IDLE; an expiring
        // open window abandons a partial programming entry
        if (enter && prog) begin
          if (w_valid) begin
            w_entry_n[(CODE_LEN-1-int'(r_idx))*4 +: 4] = digit;
            if (w_last) begin
              w_code_n  = w_entry_n;
              w_idx_n   = '0;
              w_state_n = IDLE;
            end else if (r_timer != '0) begin
              w_idx_n = r_idx + 3'd1;
            end
          end else begin
            w_err_n   = 1'b1;
            w_idx_n   = '0;
            w_state_n = IDLE;
          end
        end
`endif
      end
      LOCKOUT: begin
        if (r_timer == '0) begin
          w_state_n = IDLE;
          w_fail_n  = '0;
        end else begin
          w_timer_n = r_timer - 1'b1;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_entry <= '0;
      r_idx   <= '0;
      r_fail  <= '0;
      r_timer <= '0;
      r_err   <= 1'b0;
      unlock  <= 1'b0;
      error   <= 1'b0;
      lockout <= 1'b0;
`ifdef LOCK_REPROGRAM_EN
      r_code  <= CODE_USED;
`endif
    end else begin
      r_state <= w_state_n;
      r_entry <= w_entry_n;
      r_idx   <= w_idx_n;
      r_fail  <= w_fail_n;
      r_timer <= w_timer_n;
      r_err   <= w_err_n;
      // indication stage: one edge behind the state so unlock/error/lockout
      // rise on the second edge after the final enter
      unlock  <= (r_state == OPEN);
      lockout <= (r_state == LOCKOUT);
      error   <= r_err;
`ifdef LOCK_REPROGRAM_EN
      r_code  <= w_code_n;
`endif
    end
  end

  assign digit_idx = r_idx;
  assign fail_cnt  = r_fail;

endmodule

// File: tb/tb_lock_code_checker.sv
module tb_lock_code_checker;
  localparam int          CODE_LEN = 4;
  localparam logic [31:0] CODE     = 32'h0000_1234;
  localparam int          MAX_FAIL = 3;
  localparam int          OPEN_C   = 8;
  localparam int          LOCK_C   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit = '0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic       unlock, error, lockout;
  logic [2:0] digit_idx;
  logic [3:0] fail_cnt;

  lock_code_checker #(
    .CODE_LEN(CODE_LEN), .CODE(CODE), .MAX_FAIL(MAX_FAIL),
    .OPEN_CYCLES(OPEN_C), .LOCKOUT_CYCLES(LOCK_C)
  ) dut (
    .clk(clk), .rst(rst), .digit(digit), .enter(enter), .clear(clear),
    .unlock(unlock), .error(error), .lockout(lockout),
    .digit_idx(digit_idx), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model: timeline of windows per edge ----------
  int q[$];                 // digits of the current entry
  int n = 0;                // edge number
  int accept_from = 0;      // first edge at which inputs are honoured
  int u_lo = 0, u_hi = -1;  // edges after which unlock is expected high
  int l_lo = 0, l_hi = -1;  // edges after which lockout is expected high
  bit err_at[int];          // edges after which error is expected high
  int fail_sched[int];      // fail count taking effect at an edge
  int fail_m = 0;
  int cnt_l = 0;

  function automatic int code_digit(input int i);
    logic [31:0] c;
    c = CODE >> (4 * (CODE_LEN - 1 - i));
    return int'(c[3:0]);
  endfunction

  task automatic model_reset();
    q.delete(); err_at.delete(); fail_sched.delete();
    accept_from = 0; u_lo = 0; u_hi = -1; l_lo = 0; l_hi = -1; fail_m = 0;
  endtask

  task automatic model_edge(input bit en, input bit cl, input int d);
    bit ok;
    int nf;
    if (fail_sched.exists(n)) begin
      fail_m = fail_sched[n];
      fail_sched.delete(n);
    end
    if (n >= accept_from) begin
      if (cl) q.delete();
      else if (en) begin
        if (d > 9) err_at[n+1] = 1'b1;
        else begin
          q.push_back(d);
          if (q.size() == CODE_LEN) begin
            ok = 1'b1;
            for (int i = 0; i < CODE_LEN; i++) if (q[i] != code_digit(i)) ok = 1'b0;
            q.delete();
            if (ok) begin
              u_lo = n + 2; u_hi = n + 1 + OPEN_C;
              accept_from = n + 2 + OPEN_C;
              fail_sched[n+1] = 0;
            end else begin
              err_at[n+2] = 1'b1;
              nf = (fail_m < MAX_FAIL) ? fail_m + 1 : MAX_FAIL;
              fail_sched[n+1] = nf;
              if (nf == MAX_FAIL) begin
                l_lo = n + 2; l_hi = n + 1 + LOCK_C;
                accept_from = n + 2 + LOCK_C;
                fail_sched[n+1+LOCK_C] = 0;
              end else accept_from = n + 2;
            end
          end
        end
      end
    end
  endtask

  // one clock: drive, sample on the edge, compare just after it
  task automatic step(input bit en, input bit cl, input logic [3:0] d);
    enter = en; clear = cl; digit = d;
    @(posedge clk);
    n++;
    model_edge(en, cl, int'(d));
    #1;
    enter = 1'b0; clear = 1'b0;
    chk("unlock",    unlock,    (n >= u_lo && n <= u_hi));
    chk("lockout",   lockout,   (n >= l_lo && n <= l_hi));
    chk("error",     error,     err_at.exists(n));
    chk("digit_idx", digit_idx, q.size());
    chk("fail_cnt",  fail_cnt,  fail_m);
    if (lockout) cnt_l++;
  endtask

  task automatic enter_code(input int a, input int b, input int c, input int d);
    step(1, 0, 4'(a)); step(1, 0, 4'(b)); step(1, 0, 4'(c)); step(1, 0, 4'(d));
  endtask

  task automatic run_idle(input int k, output int u_cnt, output int u_first);
    u_cnt = 0; u_first = 0;
    for (int i = 1; i <= k; i++) begin
      step(0, 0, 4'd0);
      if (unlock) begin
        u_cnt++;
        if (u_first == 0) u_first = i;
      end
    end
  endtask

  // asynchronous reset between edges; outputs must clear without a clock
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_unlock"},  unlock,    0);
    chk({tag, "_lockout"}, lockout,   0);
    chk({tag, "_error"},   error,     0);
    chk({tag, "_idx"},     digit_idx, 0);
    chk({tag, "_fail"},    fail_cnt,  0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int uc, uf, r;
    // power-on reset held across a few edges
    repeat (2) @(posedge clk);
    do_reset("por");

    // correct code: latency and open length
    enter_code(1, 2, 3, 4);
    run_idle(12, uc, uf);
    chk("open_lat", uf, 2);
    chk("open_len", uc, OPEN_C);

    // one mismatch, then success clears the count
    enter_code(1, 2, 3, 5);
    run_idle(3, uc, uf);
    chk("fail_one", fail_cnt, 1);
    enter_code(1, 2, 3, 4);
    run_idle(12, uc, uf);
    chk("open_after_miss", uc, OPEN_C);
    chk("fail_zero", fail_cnt, 0);

    // three mismatches -> lockout; code ignored during lockout
    enter_code(9, 9, 9, 9); run_idle(3, uc, uf);
    enter_code(9, 9, 9, 9); run_idle(3, uc, uf);
    cnt_l = 0;
    enter_code(9, 9, 9, 9); run_idle(2, uc, uf);
    chk("lock_on", lockout, 1);
    chk("lock_fail", fail_cnt, MAX_FAIL);
    enter_code(1, 2, 3, 4);
    run_idle(20, uc, uf);
    chk("lock_no_open", uc, 0);
    chk("lock_len", cnt_l, LOCK_C);
    chk("lock_fail_clr", fail_cnt, 0);
    enter_code(1, 2, 3, 4);
    run_idle(12, uc, uf);
    chk("open_after_lock", uc, OPEN_C);

    // clear wins over a simultaneous enter
    step(1, 0, 4'd1); step(1, 0, 4'd2); step(1, 1, 4'd3);
    chk("clr_idx", digit_idx, 0);
    enter_code(1, 2, 3, 4);
    run_idle(12, uc, uf);
    chk("open_after_clr", uc, OPEN_C);

    // invalid digit mid-entry
    step(1, 0, 4'd1); step(1, 0, 4'hA);
    chk("inv_idx", digit_idx, 1);
    step(1, 0, 4'd2);
    chk("inv_err", error, 1);
    step(1, 0, 4'd3); step(1, 0, 4'd4);
    run_idle(12, uc, uf);
    chk("open_after_inv", uc, OPEN_C);

    // reset mid-open and mid-lockout
    enter_code(1, 2, 3, 4); run_idle(4, uc, uf);
    chk("mid_open", unlock, 1);
    do_reset("rst_open");
    enter_code(5, 5, 5, 5); run_idle(3, uc, uf);
    enter_code(5, 5, 5, 5); run_idle(3, uc, uf);
    enter_code(5, 5, 5, 5); run_idle(5, uc, uf);
    chk("mid_lock", lockout, 1);
    do_reset("rst_lock");
    enter_code(1, 2, 3, 4);
    run_idle(12, uc, uf);
    chk("open_after_rst", uc, OPEN_C);

    // randomized traffic biased toward the right code
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) do_reset("rnd_rst");
      r = $urandom_range(0, 99);
      if (r < 45)      step(1, 0, 4'(code_digit(q.size() % CODE_LEN)));
      else if (r < 65) step(1, 0, 4'($urandom_range(0, 9)));
      else if (r < 70) step(1, 0, 4'($urandom_range(10, 15)));
      else if (r < 74) step(1'($urandom_range(0, 1)), 1, 4'($urandom_range(0, 15)));
      else             step(0, 0, 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
